digit_splitter_seq: RTL and testbench
=====================================

# digit_splitter_seq

Sequential, parametrised binary-to-BCD digit splitter for the stopwatch/clock display path. It converts an unsigned binary value into `NUM_DIGITS` BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock, under a start/busy/valid handshake. It also flags values that do not fit in `NUM_DIGITS` digits and blanks selected digits for the adjust-mode blink. It sits between the time counters or UART command decoder and the FND display controller.

## Interface
- `DATA_WIDTH`, 14: width of the binary input; also the number of conversion cycles.
- `NUM_DIGITS`, 4: number of BCD output digits; must be ≥ 1.
- `BLANK_CODE`, 4'hE: nibble driven on a blanked digit.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  conversion request; sampled only while `o_busy`=0.
- `i_data`  in  DATA_WIDTH  unsigned binary value; latched on an accepted `i_start`.
- `i_blank_mask`  in  NUM_DIGITS  per-digit blank select; bit k selects digit k, where k=0 is the ones digit.
- `i_on_off`  in  1  blink phase; 0 = blank the selected digits, 1 = show them.
- `o_busy`  out  1  high while a conversion is in progress.
- `o_valid`  out  1  one-cycle pulse when a new result is loaded.
- `o_overflow`  out  1  last result was ≥ 10^NUM_DIGITS; held until the next result loads.
- `o_digits`  out  4*NUM_DIGITS  BCD digits after blanking; digit k occupies bits [4k+3:4k].

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE → CONV on `i_start`=1. On that edge: `i_data` goes into the shift register, the BCD accumulator clears, the bit counter clears, and the overflow sticky clears.
  - CONV: each cycle, every accumulator nibble ≥ 5 first gets +3. Then {accumulator, shift} shifts left by 1.
  - CONV: any 1 shifted out of the top of the accumulator sets the overflow sticky. The discarded bit carries weight 10^NUM_DIGITS, so the kept digits equal value mod 10^NUM_DIGITS.
  - CONV → DONE after exactly DATA_WIDTH shifts, when the counter reaches DATA_WIDTH-1.
  - DONE: the result register and `o_overflow` load from the accumulator and sticky; `o_valid`=1. Unconditional → IDLE, or → CONV if `i_start`=1 (back-to-back accepted).
- `o_busy`=1 only in CONV.
- `i_start` is ignored in CONV; the request is dropped, not queued.
- Blanking is combinational on the result register: digit k = `BLANK_CODE` when `i_blank_mask`[k]=1 and `i_on_off`=0; otherwise it is the stored digit. Mask and blink changes are visible the same cycle and never disturb the conversion.
- Widths: accumulator is 4*NUM_DIGITS bits. Counter is wide enough for DATA_WIDTH-1. No sign handling.

## Timing
- Reset values, asynchronous: state=IDLE, `o_busy`=0, `o_valid`=0, `o_overflow`=0, result register=0. `o_digits` therefore shows all 0 digits, or `BLANK_CODE` on masked digits when `i_on_off`=0.
- Latency: with `i_start` accepted at edge 0, `o_busy` is high in cycles 1..DATA_WIDTH. `o_valid` and the new `o_digits` appear in cycle DATA_WIDTH+1.
- Throughput: one result per DATA_WIDTH+1 cycles, using back-to-back start in DONE.
- `o_digits` and `o_overflow` hold the previous result throughout CONV; there are no intermediate values.
- Reset asserted mid-conversion aborts immediately and returns everything to reset values. No `o_valid` is produced for the aborted request.
- Start arriving in the same cycle as DONE: the new request is accepted, `o_valid` still pulses for the old result, and `o_busy` rises next cycle.

## Configuration
- `DIGIT_SPLITTER_SATURATE_EN`
  - Defined: on overflow, the result register loads all digits = 9, and `o_overflow`=1.
  - Undefined: on overflow, the result register loads value mod 10^NUM_DIGITS, and `o_overflow`=1.
  - Non-overflow results are identical in both builds.

## Test plan
All scenarios use the default parameters.
- Reset, then `i_data`=1234 with `i_start` pulse → `o_busy` high 14 cycles; `o_valid` in cycle 15; `o_digits`=16'h1234; `o_overflow`=0.
- Boundaries 0, 9, 10, 9999 → 16'h0000, 16'h0009, 16'h0010, 16'h9999; no overflow.
- Overflow: `i_data`=12345 → `o_overflow`=1; `o_digits`=16'h9999 with `DIGIT_SPLITTER_SATURATE_EN`, 16'h2345 without.
- Blanking: result 16'h5678, `i_blank_mask`=4'b0011, toggle `i_on_off` 1→0→1 → 16'h5678, 16'h56EE, 16'h5678, each in the same cycle as the toggle.
- Handshake: second `i_start` (value 42) mid-CONV → ignored, first result 1234 unchanged. A start (value 42) in the DONE cycle → accepted, 16'h0042 valid 15 cycles later.
- `rst_n` low for 1 cycle at CONV cycle 7 → all outputs return to reset values immediately; no `o_valid`; next start converts normally.

Source files
------------

// File: rtl/digit_splitter_seq_if.sv
// Start/busy/valid bundle for the binary-to-BCD digit splitter.
// master drives requests and blanking controls; slave returns status and digits.
interface digit_splitter_seq_if #(
   parameter int DATA_WIDTH = 14,
   parameter int NUM_DIGITS = 4
);
   logic                    i_start;
   logic [DATA_WIDTH-1:0]   i_data;
   logic [NUM_DIGITS-1:0]   i_blank_mask;
   logic                    i_on_off;
   logic                    o_busy;
   logic                    o_valid;
   logic                    o_overflow;
   logic [4*NUM_DIGITS-1:0] o_digits;

   modport master (
      output i_start,
      output i_data,
      output i_blank_mask,
      output i_on_off,
      input  o_busy,
      input  o_valid,
      input  o_overflow,
      input  o_digits
   );

   modport slave (
      input  i_start,
      input  i_data,
      input  i_blank_mask,
      input  i_on_off,
      output o_busy,
      output o_valid,
      output o_overflow,
      output o_digits
   );
endinterface

// File: rtl/digit_splitter_seq.sv
// Iterative double-dabble binary-to-BCD splitter, one bit per clock, with blanking.
// Define DIGIT_SPLITTER_SATURATE_EN to clamp overflowed results to all nines.
module digit_splitter_seq #(
   parameter int         DATA_WIDTH = 14,
   parameter int         NUM_DIGITS = 4,
   parameter logic [3:0] BLANK_CODE = 4'hE
) (
   input logic               clk,
   input logic               rst_n,
   digit_splitter_seq_if.slave bus
);
   localparam int ACC_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

   state_e                state_q, state_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  stk_q, stk_d;
   logic [ACC_W-1:0]      res_q, res_d;
   logic                  ovf_q, ovf_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;

   logic [ACC_W-1:0]      adj;
   logic [ACC_W-1:0]      acc_nx;
   logic                  out_bit;
   logic                  accept;
   logic [ACC_W-1:0]      digits;

   // add-3 on every nibble >= 5, then shift one input bit in
   always_comb begin
      adj = acc_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (adj[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
      out_bit = adj[ACC_W-1];
      acc_nx  = {adj[ACC_W-2:0], shift_q[DATA_WIDTH-1]};
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      stk_d   = stk_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: accept = bus.i_start;
         CONV: begin
            acc_d   = acc_nx;
            shift_d = shift_q << 1;
            stk_d   = stk_q | out_bit;
            cnt_d   = cnt_q + CNT_W'(1);
            busy_d  = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               ovf_d   = stk_d;
`ifdef DIGIT_SPLITTER_SATURATE_EN
               res_d   = stk_d ? {NUM_DIGITS{4'h9}} : acc_nx;
`else
               res_d   = acc_nx;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
            accept  = bus.i_start;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d = CONV;
         shift_d = bus.i_data;
         acc_d   = '0;
         cnt_d   = '0;
         stk_d   = 1'b0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         stk_q   <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         stk_q   <= stk_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      digits = res_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bus.i_blank_mask[k] && !bus.i_on_off)
            digits[4*k +: 4] = BLANK_CODE;
      end
   end

   assign bus.o_busy     = busy_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_overflow = ovf_q;
   assign bus.o_digits   = digits;
endmodule

// File: tb/tb_digit_splitter_seq.sv
// Self-checking bench for digit_splitter_seq: vector table, scoreboard queue,
// and hand-written handshake, blanking and reset-abort sequences.
module tb_digit_splitter_seq;
   localparam int DW = 14;
   localparam int ND = 4;

   typedef struct {
      logic [DW-1:0]   data;
      logic [4*ND-1:0] digits;
      logic            ovf;
   } vec_t;

   typedef struct {
      logic [4*ND-1:0] digits;
      logic            ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   exp_t sb[$];

   digit_splitter_seq_if #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) bus ();

   digit_splitter_seq #(
      .DATA_WIDTH(DW),
      .NUM_DIGITS(ND),
      .BLANK_CODE(4'hE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every valid pulse pops one expected result
   always @(negedge clk) begin
      if (rst_n && bus.o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_digits", 32'(bus.o_digits), 32'(e.digits));
            chk("sb_overflow", 32'(bus.o_overflow), 32'(e.ovf));
         end
      end
   end

   task automatic wait_valid(output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (!bus.o_valid && n < 100) begin
         if (bus.o_busy) nbusy++;
         tick();
         n++;
      end
      if (!bus.o_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic push(input logic [4*ND-1:0] d, input logic o);
      exp_t e;
      e.digits = d;
      e.ovf = o;
      sb.push_back(e);
   endtask

   task automatic start(input logic [DW-1:0] d);
      bus.i_start = 1'b1;
      bus.i_data = d;
      tick();
      bus.i_start = 1'b0;
   endtask

   vec_t tbl[8];
   int   n, nb, vcnt;

   initial begin
      tbl[0] = '{14'd1234,  16'h1234, 1'b0};
      tbl[1] = '{14'd0,     16'h0000, 1'b0};
      tbl[2] = '{14'd9,     16'h0009, 1'b0};
      tbl[3] = '{14'd10,    16'h0010, 1'b0};
      tbl[4] = '{14'd9999,  16'h9999, 1'b0};
`ifdef DIGIT_SPLITTER_SATURATE_EN
      tbl[5] = '{14'd12345, 16'h9999, 1'b1};
      tbl[6] = '{14'd16383, 16'h9999, 1'b1};
`else
      tbl[5] = '{14'd12345, 16'h2345, 1'b1};
      tbl[6] = '{14'd16383, 16'h6383, 1'b1};
`endif
      tbl[7] = '{14'd5678,  16'h5678, 1'b0};

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_data = '0;
      bus.i_blank_mask = 4'b1111;
      bus.i_on_off = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
      chk("rst_blanked", 32'(bus.o_digits), 32'h0000_EEEE);
      bus.i_on_off = 1'b1;
      #1;
      chk("rst_digits", 32'(bus.o_digits), 32'h0);
      bus.i_blank_mask = '0;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         push(tbl[i].digits, tbl[i].ovf);
         start(tbl[i].data);
         wait_valid(n, nb);
         chk("latency", 32'(n + 1), 32'd15);
         chk("busy_cycles", 32'(nb), 32'd14);
         chk("busy_in_done", 32'(bus.o_busy), 32'd0);
         tick();
         chk("valid_one_cycle", 32'(bus.o_valid), 32'd0);
         chk("hold_digits", 32'(bus.o_digits), 32'(tbl[i].digits));
      end

      // blink: masked low digits toggle with i_on_off in the same cycle
      bus.i_blank_mask = 4'b0011;
      bus.i_on_off = 1'b1;
      #1;
      chk("blink_on", 32'(bus.o_digits), 32'h5678);
      bus.i_on_off = 1'b0;
      #1;
      chk("blink_off", 32'(bus.o_digits), 32'h56EE);
      bus.i_on_off = 1'b1;
      #1;
      chk("blink_on2", 32'(bus.o_digits), 32'h5678);
      bus.i_blank_mask = '0;

      // start while busy is dropped
      push(16'h1234, 1'b0);
      start(14'd1234);
      repeat (4) tick();
      chk("busy_mid", 32'(bus.o_busy), 32'd1);
      chk("hold_in_conv", 32'(bus.o_digits), 32'h5678);
      start(14'd42);
      wait_valid(n, nb);
      chk("ignored_latency", 32'(n + 6), 32'd15);
      vcnt = 0;
      tick();
      repeat (20) begin
         if (bus.o_valid) vcnt++;
         tick();
      end
      chk("no_extra_valid", 32'(vcnt), 32'd0);
      chk("ignored_result", 32'(bus.o_digits), 32'h1234);

      // start during DONE is accepted back-to-back
      push(16'h1234, 1'b0);
      start(14'd1234);
      wait_valid(n, nb);
      push(16'h0042, 1'b0);
      start(14'd42);
      chk("b2b_busy", 32'(bus.o_busy), 32'd1);
      chk("b2b_old_kept", 32'(bus.o_digits), 32'h1234);
      wait_valid(n, nb);
      chk("b2b_latency", 32'(n + 1), 32'd15);
      tick();
      chk("b2b_result", 32'(bus.o_digits), 32'h0042);

      // overflowed result, then abort a conversion with reset
      push(tbl[5].digits, 1'b1);
      start(14'd12345);
      wait_valid(n, nb);
      tick();
      start(14'd777);
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.o_busy), 32'd0);
      chk("abort_valid", 32'(bus.o_valid), 32'd0);
      chk("abort_ovf", 32'(bus.o_overflow), 32'd0);
      chk("abort_digits", 32'(bus.o_digits), 32'h0);
      tick();
      rst_n = 1'b1;
      vcnt = 0;
      repeat (20) begin
         if (bus.o_valid) vcnt++;
         tick();
      end
      chk("abort_no_valid", 32'(vcnt), 32'd0);
      push(16'h0321, 1'b0);
      start(14'd321);
      wait_valid(n, nb);
      chk("post_abort_lat", 32'(n + 1), 32'd15);
      tick();
      chk("post_abort_res", 32'(bus.o_digits), 32'h0321);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
